id_ex_control: RTL and testbench

- Producer side of the ALUOp/Funct interface consumed by the ALU control decoder.
- Decodes the ID-stage instruction into main control signals, ALUOp and the 4-bit Funct field {instr[30], funct3}.
- Registers all of them into the ID/EX pipeline boundary.
- Detects load-use hazards, inserts bubbles on stall or flush, and counts inserted bubbles for the selection-sort performance runs.

---
 rtl/id_ex_control_pkg.sv | 28 ++
 rtl/main_decoder.sv | 56 +++++
 rtl/id_ex_control.sv | 118 +++++++++++
 tb/tb_id_ex_control.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_control_pkg.sv
// Shared encodings for the ID-stage decoder and the ID/EX control register.
// The control bundle is packed so a bubble is a single all-zero constant.
package id_ex_control_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [3:0] funct;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/main_decoder.sv
// Purely combinational main decoder: opcode/funct fields to the control bundle,
// plus whether rs2 is a real source and whether the opcode is unsupported.
module main_decoder
  import id_ex_control_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_bit30,
  output ctrl_t      o_ctrl,
  output logic       o_uses_rs2,
  output logic       o_illegal
);

  always_comb begin
    o_ctrl     = CTRL_BUBBLE;
    o_uses_rs2 = 1'b0;
    o_illegal  = 1'b0;
    unique case (i_opcode)
      OP_R: begin
        o_ctrl.alu_op    = ALUOP_FUNCT;
        o_ctrl.funct     = {i_bit30, i_funct3};
        o_ctrl.reg_write = 1'b1;
        o_uses_rs2       = 1'b1;
      end
      OP_IMM: begin
        o_ctrl.alu_op    = ALUOP_ADD;
        o_ctrl.funct     = {1'b0, i_funct3};
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
      end
      OP_LOAD: begin
        o_ctrl.alu_op     = ALUOP_ADD;
        o_ctrl.funct      = {1'b0, i_funct3};
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_read   = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.alu_src    = 1'b1;
      end
      OP_STORE: begin
        o_ctrl.alu_op    = ALUOP_ADD;
        o_ctrl.funct     = {1'b0, i_funct3};
        o_ctrl.mem_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_uses_rs2       = 1'b1;
      end
      OP_BRANCH: begin
        o_ctrl.alu_op = ALUOP_SUB;
        o_ctrl.funct  = {1'b0, i_funct3};
        o_ctrl.branch = 1'b1;
        o_uses_rs2    = 1'b1;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_control.sv
// ID/EX control boundary: decodes the ID instruction, detects load-use hazards,
// inserts bubbles on stall/flush/idle/illegal, and keeps saturating event counters.
module id_ex_control
  import id_ex_control_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr_id,
  input  logic             valid_id,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       ALUOp_ex,
  output logic [3:0]       Funct_ex,
  output logic             RegWrite_ex,
  output logic             MemRead_ex,
  output logic             MemWrite_ex,
  output logic             MemtoReg_ex,
  output logic             ALUSrc_ex,
  output logic             Branch_ex,
  output logic [4:0]       rs1_ex,
  output logic [4:0]       rs2_ex,
  output logic [4:0]       rd_ex,
  output logic             valid_ex,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  ctrl_t      w_ctrl;
  logic       w_uses_rs2;
  logic       w_illegal;
  logic [4:0] w_rs1_id;
  logic [4:0] w_rs2_id;
  logic [4:0] w_rd_id;
  logic       w_hazard;
  logic       w_bubble;
  logic [5:0] w_unused_funct7;

  ctrl_t            r_ctrl;
  logic [4:0]       r_rs1;
  logic [4:0]       r_rs2;
  logic [4:0]       r_rd;
  logic             r_valid;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic [CNT_W-1:0] r_illegal_cnt;

  main_decoder u_main_decoder (
    .i_opcode   (instr_id[6:0]),
    .i_funct3   (instr_id[14:12]),
    .i_bit30    (instr_id[30]),
    .o_ctrl     (w_ctrl),
    .o_uses_rs2 (w_uses_rs2),
    .o_illegal  (w_illegal)
  );

  assign w_rs1_id        = instr_id[19:15];
  assign w_rs2_id        = instr_id[24:20];
  assign w_rd_id         = instr_id[11:7];
  assign w_unused_funct7 = {instr_id[31], instr_id[29:25]};

  // A load in EX whose destination feeds the ID instruction must wait one cycle.
  assign w_hazard = valid_id & ~flush & r_valid & r_ctrl.mem_read & (r_rd != 5'd0) &
                    ((r_rd == w_rs1_id) | (w_uses_rs2 & (r_rd == w_rs2_id)));
  assign stall    = w_hazard;
  assign w_bubble = flush | w_hazard | ~valid_id | w_illegal;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl  <= CTRL_BUBBLE;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_rd    <= '0;
      r_valid <= 1'b0;
    end else if (w_bubble) begin
      r_ctrl  <= CTRL_BUBBLE;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_rd    <= '0;
      r_valid <= 1'b0;
    end else begin
      r_ctrl  <= w_ctrl;
      r_rs1   <= w_rs1_id;
      r_rs2   <= w_uses_rs2 ? w_rs2_id : 5'd0;
      r_rd    <= w_ctrl.reg_write ? w_rd_id : 5'd0;
      r_valid <= 1'b1;
    end
  end

  // Counters saturate so long performance runs never report a wrapped value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bubble_cnt  <= '0;
      r_illegal_cnt <= '0;
    end else begin
      if ((flush | w_hazard) && (r_bubble_cnt != {CNT_W{1'b1}}))
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
      if (valid_id && !flush && w_illegal && (r_illegal_cnt != {CNT_W{1'b1}}))
        r_illegal_cnt <= r_illegal_cnt + 1'b1;
    end
  end

  assign ALUOp_ex    = r_ctrl.alu_op;
  assign Funct_ex    = r_ctrl.funct;
  assign RegWrite_ex = r_ctrl.reg_write;
  assign MemRead_ex  = r_ctrl.mem_read;
  assign MemWrite_ex = r_ctrl.mem_write;
  assign MemtoReg_ex = r_ctrl.mem_to_reg;
  assign ALUSrc_ex   = r_ctrl.alu_src;
  assign Branch_ex   = r_ctrl.branch;
  assign rs1_ex      = r_rs1;
  assign rs2_ex      = r_rs2;
  assign rd_ex       = r_rd;
  assign valid_ex    = r_valid;
  assign bubble_cnt  = r_bubble_cnt;
  assign illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_id_ex_control.sv
// Self-checking bench: directed vector table, counter saturation runs, then
// randomized traffic against a rule-level reference model.
module tb_id_ex_control;
  import id_ex_control_pkg::*;

  localparam int CW = 5;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   instr_id;
  logic          valid_id;
  logic          flush;
  logic          stall;
  logic [1:0]    ALUOp_ex;
  logic [3:0]    Funct_ex;
  logic          RegWrite_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex, ALUSrc_ex, Branch_ex;
  logic [4:0]    rs1_ex, rs2_ex, rd_ex;
  logic          valid_ex;
  logic [CW-1:0] bubble_cnt, illegal_cnt;

  int checks = 0;
  int errors = 0;

  id_ex_control #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .instr_id(instr_id), .valid_id(valid_id), .flush(flush),
    .stall(stall), .ALUOp_ex(ALUOp_ex), .Funct_ex(Funct_ex),
    .RegWrite_ex(RegWrite_ex), .MemRead_ex(MemRead_ex), .MemWrite_ex(MemWrite_ex),
    .MemtoReg_ex(MemtoReg_ex), .ALUSrc_ex(ALUSrc_ex), .Branch_ex(Branch_ex),
    .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex), .valid_ex(valid_ex),
    .bubble_cnt(bubble_cnt), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        v, f, st;
    logic [1:0]  aop;
    logic [3:0]  fn;
    logic [5:0]  ctl;
    logic [4:0]  rd;
    logic        vex;
    int          bub, ill;
  } vec_t;

  function automatic vec_t mk(logic [31:0] ins, logic v, logic f, logic st, logic [1:0] aop,
                              logic [3:0] fn, logic [5:0] ctl, logic [4:0] rd, logic vex,
                              int bub, int ill);
    vec_t t;
    t.instr = ins; t.v = v; t.f = f; t.st = st; t.aop = aop; t.fn = fn;
    t.ctl = ctl; t.rd = rd; t.vex = vex; t.bub = bub; t.ill = ill;
    return t;
  endfunction

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OP_R};
  endfunction

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
  endfunction

  function automatic logic [31:0] enc_b(logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
    return {7'd0, rs2, rs1, f3, 5'd0, OP_BRANCH};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic v, input logic f, input logic r);
    @(negedge clk);
    instr_id = ins; valid_id = v; flush = f; reset = r;
    #1;
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  // Reference model state: what ID/EX should hold.
  logic [1:0] m_aop;
  logic [3:0] m_fn;
  logic [5:0] m_ctl;
  logic [4:0] m_rs1, m_rs2, m_rd;
  logic       m_v;
  int         m_bub, m_ill;

  task automatic model_clear();
    m_aop = 0; m_fn = 0; m_ctl = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_v = 0;
  endtask

  vec_t tbl[17];

  initial begin
    logic [31:0] add3, ld8, ins;
    logic        v, f, r, legal, u2, hz;
    logic [1:0]  aop;
    logic [5:0]  ctl;
    logic [6:0]  op;

    reset = 1'b1; valid_id = 1'b0; flush = 1'b0; instr_id = '0;
    add3 = enc_r(7'd0, 5'd2, 5'd1, 3'd0, 5'd3);
    ld8  = enc_i(12'd0, 5'd9, 3'b011, 5'd8, OP_LOAD);

    // Reset held two cycles with a real instruction presented.
    drive(add3, 1'b1, 1'b0, 1'b1); edge_wait();
    drive(add3, 1'b1, 1'b0, 1'b1); edge_wait();
    chk("reset_outputs",
        {ALUOp_ex, Funct_ex, RegWrite_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex, ALUSrc_ex,
         Branch_ex, rs1_ex, rs2_ex, rd_ex, valid_ex}, 64'd0);
    chk("reset_stall", stall, 0);
    chk("reset_counters", {bubble_cnt, illegal_cnt}, 0);

    //           instr                                          v  f  st aop    fn       ctl        rd  vex bub ill
    tbl[0]  = mk(enc_r(7'h20, 5'd7, 5'd6, 3'd0, 5'd5),          1, 0, 0, 2'b10, 4'b1000, 6'b100000, 5,  1,  0,  0);
    tbl[1]  = mk(enc_i(12'd3, 5'd4, 3'b001, 5'd4, OP_IMM),      1, 0, 0, 2'b00, 4'b0001, 6'b100010, 4,  1,  0,  0);
    tbl[2]  = mk(enc_b(5'd2, 5'd1, 3'd0),                       1, 0, 0, 2'b01, 4'b0000, 6'b000001, 0,  1,  0,  0);
    tbl[3]  = mk(ld8,                                           1, 0, 0, 2'b00, 4'b0011, 6'b110110, 8,  1,  0,  0);
    tbl[4]  = mk(enc_r(7'd0, 5'd1, 5'd8, 3'd0, 5'd10),          1, 0, 1, 2'b00, 4'b0000, 6'b000000, 0,  0,  1,  0);
    tbl[5]  = mk(enc_r(7'd0, 5'd1, 5'd8, 3'd0, 5'd10),          1, 0, 0, 2'b10, 4'b0000, 6'b100000, 10, 1,  1,  0);
    tbl[6]  = mk(enc_i(12'd0, 5'd9, 3'b011, 5'd0, OP_LOAD),     1, 0, 0, 2'b00, 4'b0011, 6'b110110, 0,  1,  1,  0);
    tbl[7]  = mk(enc_r(7'd0, 5'd1, 5'd0, 3'd0, 5'd10),          1, 0, 0, 2'b10, 4'b0000, 6'b100000, 10, 1,  1,  0);
    tbl[8]  = mk(ld8,                                           1, 0, 0, 2'b00, 4'b0011, 6'b110110, 8,  1,  1,  0);
    tbl[9]  = mk(enc_i(12'd8, 5'd1, 3'd0, 5'd8, OP_IMM),        1, 0, 0, 2'b00, 4'b0000, 6'b100010, 8,  1,  1,  0);
    tbl[10] = mk(ld8,                                           1, 0, 0, 2'b00, 4'b0011, 6'b110110, 8,  1,  1,  0);
    tbl[11] = mk(enc_s(12'd0, 5'd8, 5'd2, 3'b011),              1, 0, 1, 2'b00, 4'b0000, 6'b000000, 0,  0,  2,  0);
    tbl[12] = mk(enc_s(12'd0, 5'd8, 5'd2, 3'b011),              1, 0, 0, 2'b00, 4'b0011, 6'b001010, 0,  1,  2,  0);
    tbl[13] = mk(ld8,                                           1, 0, 0, 2'b00, 4'b0011, 6'b110110, 8,  1,  2,  0);
    tbl[14] = mk(enc_r(7'd0, 5'd1, 5'd8, 3'd0, 5'd10),          1, 1, 0, 2'b00, 4'b0000, 6'b000000, 0,  0,  3,  0);
    tbl[15] = mk(32'h0000007F,                                  1, 0, 0, 2'b00, 4'b0000, 6'b000000, 0,  0,  3,  1);
    tbl[16] = mk(add3,                                          0, 0, 0, 2'b00, 4'b0000, 6'b000000, 0,  0,  3,  1);

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].instr, tbl[i].v, tbl[i].f, 1'b0);
      chk($sformatf("vec%0d_stall", i), stall, tbl[i].st);
      edge_wait();
      chk($sformatf("vec%0d_ex", i),
          {ALUOp_ex, Funct_ex, RegWrite_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex, ALUSrc_ex,
           Branch_ex, rd_ex, valid_ex},
          {tbl[i].aop, tbl[i].fn, tbl[i].ctl, tbl[i].rd, tbl[i].vex});
      chk($sformatf("vec%0d_cnt", i), {bubble_cnt, illegal_cnt},
          {tbl[i].bub[CW-1:0], tbl[i].ill[CW-1:0]});
    end

    // Drive both counters into saturation and beyond.
    for (int i = 0; i < CMAX + 4; i++) begin
      drive(32'h0000007F, 1'b1, 1'b0, 1'b0); edge_wait();
    end
    chk("illegal_saturate", illegal_cnt, CMAX);
    for (int i = 0; i < CMAX + 4; i++) begin
      drive(add3, 1'b1, 1'b1, 1'b0); edge_wait();
    end
    chk("bubble_saturate", bubble_cnt, CMAX);
    chk("illegal_held", illegal_cnt, CMAX);

    // Randomized traffic against the reference model.
    drive(add3, 1'b1, 1'b0, 1'b1); edge_wait();
    model_clear(); m_bub = 0; m_ill = 0;
    for (int n = 0; n < 3000; n++) begin
      ins = $urandom;
      case ($urandom_range(0, 5))
        0: op = OP_R;
        1: op = OP_IMM;
        2: op = OP_LOAD;
        3: op = OP_STORE;
        4: op = OP_BRANCH;
        default: op = 7'($urandom_range(0, 127));
      endcase
      ins[6:0]   = op;
      ins[11:7]  = 5'($urandom_range(0, 3));
      ins[19:15] = 5'($urandom_range(0, 3));
      ins[24:20] = 5'($urandom_range(0, 3));
      v = ($urandom_range(0, 9) != 0);
      f = ($urandom_range(0, 6) == 0);
      r = ($urandom_range(0, 59) == 0);

      legal = 1; u2 = 0; aop = 2'b00; ctl = 6'b000000;   // ctl = {RW,MR,MW,M2R,AS,BR}
      case (op)
        OP_R:      begin aop = 2'b10; ctl = 6'b100000; u2 = 1; end
        OP_IMM:    ctl = 6'b100010;
        OP_LOAD:   ctl = 6'b110110;
        OP_STORE:  begin ctl = 6'b001010; u2 = 1; end
        OP_BRANCH: begin aop = 2'b01; ctl = 6'b000001; u2 = 1; end
        default:   legal = 0;
      endcase
      hz = v && !f && m_v && m_ctl[4] && (m_rd != 0) &&
           ((m_rd == ins[19:15]) || (u2 && m_rd == ins[24:20]));

      drive(ins, v, f, r);
      chk("rnd_stall", stall, hz);
      edge_wait();

      if (r) begin
        model_clear(); m_bub = 0; m_ill = 0;
      end else begin
        if (f || hz) m_bub = (m_bub < CMAX) ? m_bub + 1 : m_bub;
        if (v && !f && !legal) m_ill = (m_ill < CMAX) ? m_ill + 1 : m_ill;
        if (f || hz || !v || !legal) model_clear();
        else begin
          m_aop = aop;
          m_fn  = {(op == OP_R) ? ins[30] : 1'b0, ins[14:12]};
          m_ctl = ctl;
          m_rs1 = ins[19:15];
          m_rs2 = u2 ? ins[24:20] : 5'd0;
          m_rd  = ctl[5] ? ins[11:7] : 5'd0;
          m_v   = 1;
        end
      end
      chk("rnd_ex",
          {ALUOp_ex, Funct_ex, RegWrite_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex, ALUSrc_ex,
           Branch_ex, rs1_ex, rs2_ex, rd_ex, valid_ex},
          {m_aop, m_fn, m_ctl, m_rs1, m_rs2, m_rd, m_v});
      chk("rnd_cnt", {bubble_cnt, illegal_cnt}, {m_bub[CW-1:0], m_ill[CW-1:0]});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
